// File: rtl/ahb_lite_req_arbiter.sv
// Round-robin arbiter fronting one AHB-lite slave for NREQ clients.
// Single NONSEQ transfers, HREADY wait states, replay after ERROR.
module ahb_lite_req_arbiter #(
  parameter int          NREQ      = 2,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*3-1:0]        req_size,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     HSEL,
  output logic [ADDR_W-1:0]        HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic [2:0]               HBURST,
  output logic [3:0]               HPROT,
  output logic [DATA_W-1:0]        HWDATA,
  input  logic [DATA_W-1:0]        HRDATA,
  input  logic                     HREADY,
  input  logic                     HRESP
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [IW-1:0]     ptr_q;
  logic              a_vld_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [IW-1:0]     a_own_q;
  logic [DATA_W-1:0] pend_q;
  logic              d_vld_q;
  logic [IW-1:0]     d_own_q;
  logic              d_wr_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              replay_q;
  logic [NREQ-1:0]   rsp_vld_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   own_oh;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [2:0]        win_size;
  logic              win_write;
  logic              accept;

  // Search starts just past the last granted client.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    own_oh = '0;
    own_oh[d_own_q] = 1'b1;
  end

  assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
  assign win_size  = req_size[win_idx*3 +: 3];
  assign win_write = req_write[win_idx];

  assign accept    = HREADY && !replay_q && win_found;
  assign req_ready = accept ? win_oh : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q       <= '0;
      a_vld_q     <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      a_own_q     <= '0;
      pend_q      <= '0;
      d_vld_q     <= 1'b0;
      d_own_q     <= '0;
      d_wr_q      <= 1'b0;
      hwdata_q    <= '0;
      replay_q    <= 1'b0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (HREADY) begin
      rsp_vld_q <= d_vld_q ? own_oh : '0;
      if (d_vld_q) begin
        rsp_rdata_q <= d_wr_q ? '0 : HRDATA;
        rsp_err_q   <= HRESP;
      end
      d_vld_q  <= a_vld_q;
      d_own_q  <= a_own_q;
      d_wr_q   <= hwrite_q;
      hwdata_q <= pend_q;
      if (replay_q) begin
        a_vld_q  <= 1'b1;
        replay_q <= 1'b0;
      end else if (win_found) begin
        a_vld_q  <= 1'b1;
        haddr_q  <= win_addr;
        hwrite_q <= win_write;
        hsize_q  <= win_size;
        a_own_q  <= win_idx;
        pend_q   <= win_wdata;
        ptr_q    <= win_idx;
      end else begin
        a_vld_q <= 1'b0;
      end
    end else begin
      rsp_vld_q <= '0;
      // First ERROR cycle: cancel the queued address phase for reissue.
      if (d_vld_q && HRESP) begin
        a_vld_q  <= 1'b0;
        replay_q <= replay_q | a_vld_q;
      end
    end
  end

  assign HSEL      = a_vld_q;
  assign HTRANS    = a_vld_q ? TR_NONSEQ : TR_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/ahb_lite_req_arbiter.md
Name: ahb_lite_req_arbiter

Overview:
- Round-robin arbiter and AHB-lite master front-end that shares one AHB-lite slave (the ahb3liten memory slave) between NREQ simple request/response clients.
- Issues single transfers only (HBURST=SINGLE, HTRANS NONSEQ/IDLE).
- Runs the pipelined address/data phases, honours HREADY wait states, and replays the transfer cancelled by a two-cycle ERROR response.
- Sits between the bus clients and the slave's HSEL/HADDR/HTRANS/HREADYOUT/HRESP pins.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA/HRDATA width
HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable data access)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  async active-low reset
req_valid  in  NREQ  per-client request valid
req_ready  out  NREQ  per-client accept; a transfer is taken when valid&ready
req_write  in  NREQ  1=write
req_addr  in  NREQ*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data
req_size  in  NREQ*3  packed HSIZE
rsp_valid  out  NREQ  one-cycle completion pulse to the owning client
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  1=transfer got ERROR, valid with rsp_valid
HSEL  out  1  slave select
HADDR  out  ADDR_W  address phase
HTRANS  out  2  00 IDLE, 10 NONSEQ
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  constant 000
HPROT  out  4  constant HPROT_VAL
HWDATA  out  DATA_W  data-phase write data
HRDATA  in  DATA_W  slave read data
HREADY  in  1  slave HREADYOUT
HRESP  in  1  slave response, 1=ERROR

Behaviour:
- Reset: HCLK is the only clock; HRESETn is asynchronous, active-low, and clears all state immediately.
  - Reset values: HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rr pointer=0, data-phase valid=0, replay=0.
- All address-phase outputs and HWDATA are registered. HSEL==(HTRANS==NONSEQ).
- Arbitration (combinational):
  - The winner is the first asserted req_valid searching from index ptr+1 upward, wrapping modulo NREQ.
  - req_ready[i] = HREADY & !replay & (i==winner). At most one bit is high.
- Accept edge (HREADY=1, winner exists, replay=0):
  - Load HADDR/HWRITE/HSIZE from the winner and set HTRANS=NONSEQ.
  - Latch the winner's wdata into the pending register, the owner id, and the write flag.
  - ptr <= winner.
- No winner at an HREADY=1 edge: HTRANS<=IDLE.
- HREADY=0 edge: all address-phase registers hold; no new accept.
- Data phase: at an HREADY=1 edge the current address phase moves to the data phase.
  - HWDATA <= pending wdata (at the same edge); data-phase owner/valid <= address-phase owner/valid.
- Completion: at an HREADY=1 edge with data-phase valid:
  - Next cycle, rsp_valid[owner]=1 for exactly one cycle.
  - rsp_rdata = HRDATA sampled at that edge (reads; 0 for writes).
  - rsp_err = HRESP.
- Latency: accept edge N; data phase starts at edge N+1; with zero wait states, rsp_valid is high in the cycle after edge N+2.
- ERROR (cycle 1 sampled HRESP=1 & HREADY=0 with data-phase valid):
  - HTRANS<=IDLE (cancel), HSEL<=0; HADDR/HWRITE/HSIZE/pending data/owner hold.
  - replay<=1 only if the address phase was NONSEQ.
- ERROR cycle 2 (HREADY=1):
  - The errored transfer completes with rsp_err=1.
  - If replay=1: the held transfer is reissued (HTRANS<=NONSEQ) instead of arbitrating, replay<=0, ptr unchanged.
- Back-to-back transfers from different clients are pipelined with no IDLE between them.
- A client may hold req_valid across several transfers; round-robin still alternates between clients when others request.
- A client dropping req_valid without handshake is allowed; it is simply not accepted.
- Reset mid-transfer: outstanding transfers are dropped, no rsp_valid is issued, and the bus returns to IDLE asynchronously.

Test Plan:
- Single client 0 write A=0x10 D=0xDEADBEEF, then read 0x10 -> HTRANS=NONSEQ one cycle each; rsp_valid[0] pulses twice; second pulse has rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both clients valid continuously, 4 transfers each -> grant order 1,0,1,0,... from reset (ptr=0); NONSEQ every cycle; each client gets 4 rsp_valid pulses.
- Slave inserts 2 wait states on a client-0 read while client 1 is valid -> HADDR/HTRANS stable while HREADY=0; req_ready all 0; client 1 accepted on the edge HREADY returns to 1.
- ERROR on client-0 write to an out-of-range address with client-1 read 0x20 in the address phase -> cycle 1: HTRANS goes to IDLE; then rsp_valid[0] with rsp_err=1; client-1 read reissued to 0x20 and completes with rsp_err=0.
- Assert HRESETn=0 mid data phase -> HTRANS=00, HSEL=0, rsp_valid=0 immediately; after release, the first accept goes to the lowest valid index after 0.
- No requests for 10 cycles -> HTRANS=IDLE, HSEL=0, no rsp_valid.
